dma_write_target: RTL and testbench

AXI4-Lite slave (write responder) terminating the single-beat writes issued by the DMA manager master. Accepts AW and W independently, range-checks the address, and presents the accepted write on a valid/ready sideband to fabric logic. Issues the B response only after the sideband consumer has accepted the write. Reads are answered with SLVERR, so an errant master never hangs the interconnect.

---
 rtl/dma_target_pkg.sv | 13 +
 rtl/dma_write_target.sv | 193 +++++++++++++++++++
 tb/tb_dma_write_target.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_target_pkg.sv
// Shared types and constants for the DMA write target: write FSM states and AXI response codes.
package dma_target_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELIVER,
    RESP
  } wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/dma_write_target.sv
// AXI4-Lite write responder: captures AW/W, range-checks the address, hands the write to fabric
// over a valid/ready sideband and answers B only after the consumer accepts. Reads get SLVERR.
module dma_write_target
  import dma_target_pkg::*;
#(
  parameter int                            C_S_AXI_ADDR_WIDTH = 32,
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_BASE          = '0,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_SPAN          = C_S_AXI_ADDR_WIDTH'('h1000)
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   address,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] strobe,
  output logic                            write_valid,
  input  logic                            write_ready,
  output logic [15:0]                     error_count
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  wr_state_t                   state_q, state_d;
  logic                        aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
  logic                        awready_q, awready_d, wready_q, wready_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_W-1:0]           strb_q, strb_d;
  logic                        wvalid_q, wvalid_d, bvalid_q, bvalid_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic [15:0]                 err_q, err_d;
  logic                        arready_q, rvalid_q;
  logic [1:0]                  rresp_q;

  // One extra bit so BASE+SPAN at the top of the address space cannot wrap to a small value.
  logic [C_S_AXI_ADDR_WIDTH:0] addr_ext, lo_ext, hi_ext;
  logic                        in_window;
  assign addr_ext  = {1'b0, addr_q};
  assign lo_ext    = {1'b0, ADDR_BASE};
  assign hi_ext    = lo_ext + {1'b0, ADDR_SPAN};
  assign in_window = (addr_ext >= lo_ext) && (addr_ext < hi_ext);

  logic unused_araddr;
  assign unused_araddr = ^S_AXI_ARADDR;

  // NOTE: every register uses non-blocking assignments and resets asynchronously, so all
  // state settles together on the edge and outputs drop the moment reset asserts.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q   <= IDLE;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      wvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      aw_cap_q  <= aw_cap_d;
      w_cap_q   <= w_cap_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      wvalid_q  <= wvalid_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      err_q     <= err_d;
    end
  end

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    aw_cap_d  = aw_cap_q;
    w_cap_d   = w_cap_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    wvalid_d  = wvalid_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (aw_cap_q && w_cap_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b0;
          if (in_window) begin
            state_d  = DELIVER;
            wvalid_d = 1'b1;
          end else begin
            state_d  = RESP;
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          end
        end else begin
          if (S_AXI_AWVALID && awready_q) begin
            aw_cap_d = 1'b1;
            addr_d   = S_AXI_AWADDR;
          end
          if (S_AXI_WVALID && wready_q) begin
            w_cap_d = 1'b1;
            data_d  = S_AXI_WDATA;
            strb_d  = S_AXI_WSTRB;
          end
          awready_d = !aw_cap_d;
          wready_d  = !w_cap_d;
        end
      end
      DELIVER: begin
        if (write_ready) begin
          state_d  = RESP;
          wvalid_d = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = RESP_OKAY;
        end
      end
      RESP: begin
        if (S_AXI_BREADY) begin
          state_d   = IDLE;
          bvalid_d  = 1'b0;
          aw_cap_d  = 1'b0;
          w_cap_d   = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read responder, independent of the write FSM: every read is answered with SLVERR.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else if (!rvalid_q) begin
      if (S_AXI_ARVALID && arready_q) begin
        arready_q <= 1'b0;
        rvalid_q  <= 1'b1;
        rresp_q   <= RESP_SLVERR;
      end else begin
        arready_q <= 1'b1;
      end
    end else if (S_AXI_RREADY) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = '0;
  assign address       = addr_q;
  assign data          = data_q;
  assign strobe        = strb_q;
  assign write_valid   = wvalid_q;
  assign error_count   = err_q;

endmodule

// File: tb/tb_dma_write_target.sv
// Self-checking bench for dma_write_target: directed scenarios plus randomized writes
// checked against a window/response model.
module tb_dma_write_target;

  localparam longint BASE = 0;
  localparam longint SPAN = 'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0, RDATA;
  logic [3:0]  WSTRB = '0;
  logic        AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0, write_ready = 0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, write_valid;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] address, data;
  logic [3:0]  strobe;
  logic [15:0] error_count;

  int n_cmp = 0;
  int n_bad = 0;
  int model_err = 0;

  always #5 clk = ~clk;

  dma_write_target dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .address(address), .data(data), .strobe(strobe),
    .write_valid(write_valid), .write_ready(write_ready), .error_count(error_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0; write_ready = 0;
  endtask

  function automatic bit model_in_window(input logic [31:0] a);
    longint ua;
    ua = a;
    return (ua >= BASE) && (ua < BASE + SPAN);
  endfunction

  // Drives one write with the given per-channel delays and reports what was observed.
  task automatic run_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int wr_dly, input int br_dly,
                           output bit got_valid, output logic [31:0] a_seen,
                           output logic [31:0] d_seen, output logic [3:0] s_seen,
                           output logic [1:0] b_seen, output int vcyc, output int lat,
                           output bit proto_ok, output bit timeout);
    bit aw_done, w_done, wr_done, b_done, aw_hs, w_hs, wr_hs, b_hs;
    int c, cap_c, bcnt;
    aw_done = 0; w_done = 0; wr_done = 0; b_done = 0;
    got_valid = 0; a_seen = '0; d_seen = '0; s_seen = '0; b_seen = 2'b11;
    vcyc = 0; lat = -1; proto_ok = 1; c = 0; cap_c = -1; bcnt = 0;
    while (!b_done && c < 100) begin
      if (write_valid) begin
        if (!got_valid) begin
          got_valid = 1; a_seen = address; d_seen = data; s_seen = strobe;
        end else if (address !== a_seen || data !== d_seen || strobe !== s_seen) begin
          proto_ok = 0;
        end
        vcyc++;
      end
      if (BVALID) begin
        bcnt++;
        if (got_valid && !wr_done) proto_ok = 0;
      end
      if (lat < 0 && cap_c >= 0 && (write_valid || BVALID)) lat = c - cap_c;
      if ((aw_done && AWREADY) || (w_done && WREADY)) proto_ok = 0;
      AWVALID = !aw_done && c >= aw_dly; AWADDR = a;
      WVALID  = !w_done && c >= w_dly;   WDATA = d; WSTRB = s;
      write_ready = write_valid && vcyc > wr_dly;
      BREADY      = BVALID && bcnt > br_dly;
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      wr_hs = write_valid && write_ready;
      b_hs  = BVALID && BREADY;
      if (b_hs) b_seen = BRESP;
      tick();
      c++;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      wr_done = wr_done | wr_hs;
      b_done  = b_done | b_hs;
      if (cap_c < 0 && aw_done && w_done) cap_c = c;
    end
    idle_inputs();
    if (b_done && !(AWREADY && WREADY)) proto_ok = 0;
    timeout = !b_done;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1;
    tick(); tick();
    n_cmp++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, write_valid, BRESP, RRESP,
         error_count, address, data, strobe, RDATA} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: some output nonzero during reset");
    end
    @(negedge clk); rst = 0;
    tick();
    n_cmp++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      n_bad++; $display("FAIL reset_release_readies: got %b want 111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_same_edge;
    AWADDR = 32'h10; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1; write_ready = 1; BREADY = 1;
    tick();
    AWVALID = 0; WVALID = 0;
    n_cmp++;
    if ({AWREADY, WREADY, write_valid} !== 3'b000) begin
      n_bad++; $display("FAIL same_edge_capture: got %b want 000", {AWREADY, WREADY, write_valid});
    end
    tick();
    n_cmp++;
    if (write_valid !== 1'b1 || address !== 32'h10 || data !== 32'hDEADBEEF || strobe !== 4'hF) begin
      n_bad++; $display("FAIL same_edge_deliver: got v=%b a=%h d=%h s=%h want v=1 a=10 d=deadbeef s=f",
                        write_valid, address, data, strobe);
    end
    tick();
    n_cmp++;
    if ({write_valid, BVALID, BRESP} !== 4'b0100) begin
      n_bad++; $display("FAIL same_edge_bresp: got %b want 0100", {write_valid, BVALID, BRESP});
    end
    tick();
    n_cmp++;
    if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
      n_bad++; $display("FAIL same_edge_ready_return: got %b want 011", {BVALID, AWREADY, WREADY});
    end
    idle_inputs();
  endtask

  task automatic test_w_leads;
    bit gv, pok, to; logic [31:0] as, ds; logic [3:0] ss; logic [1:0] bs; int vc, lat;
    run_write(32'h124, 32'hCAFE0001, 4'h3, 3, 0, 5, 0, gv, as, ds, ss, bs, vc, lat, pok, to);
    n_cmp++;
    if (to || !gv || as !== 32'h124 || ds !== 32'hCAFE0001 || ss !== 4'h3 || bs !== 2'b00) begin
      n_bad++; $display("FAIL w_leads_result: got to=%0d v=%0d a=%h d=%h s=%h b=%b want 0 1 124 cafe0001 3 00",
                        to, gv, as, ds, ss, bs);
    end
    n_cmp++;
    if (vc !== 6 || lat !== 1 || !pok) begin
      n_bad++; $display("FAIL w_leads_timing: got vcyc=%0d lat=%0d proto=%0d want 6 1 1", vc, lat, pok);
    end
  endtask

  task automatic test_window;
    bit gv, pok, to; logic [31:0] as, ds; logic [3:0] ss; logic [1:0] bs; int vc, lat;
    run_write(32'h1000, 32'h11112222, 4'hF, 0, 0, 0, 0, gv, as, ds, ss, bs, vc, lat, pok, to);
    model_err++;
    n_cmp++;
    if (to || gv || bs !== 2'b10 || lat !== 1 || !pok) begin
      n_bad++; $display("FAIL window_edge_reject: got to=%0d v=%0d b=%b lat=%0d want 0 0 10 1", to, gv, bs, lat);
    end
    n_cmp++;
    if (error_count !== 16'd1) begin
      n_bad++; $display("FAIL window_error_count: got %0d want 1", error_count);
    end
    run_write(32'hFFC, 32'h33334444, 4'hC, 0, 1, 0, 0, gv, as, ds, ss, bs, vc, lat, pok, to);
    n_cmp++;
    if (to || !gv || as !== 32'hFFC || ds !== 32'h33334444 || bs !== 2'b00 || error_count !== 16'd1) begin
      n_bad++; $display("FAIL window_last_word: got v=%0d a=%h d=%h b=%b err=%0d want 1 ffc 33334444 00 1",
                        gv, as, ds, bs, error_count);
    end
  endtask

  task automatic test_bready_stall;
    bit gv, pok, to; logic [31:0] as, ds; logic [3:0] ss; logic [1:0] bs; int vc, lat, n;
    AWADDR = 32'h20; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1; write_ready = 1; BREADY = 0;
    tick();
    AWVALID = 0; WVALID = 0;
    n = 0;
    while (!BVALID && n < 10) begin tick(); n++; end
    n_cmp++;
    if (BVALID !== 1'b1) begin
      n_bad++; $display("FAIL stall_bvalid_wait: got %b want 1", BVALID);
    end
    AWADDR = 32'h24; WDATA = 32'h5A5A5A5A; AWVALID = 1; WVALID = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({AWREADY, WREADY, BVALID} !== 3'b001) begin
        n_bad++; $display("FAIL stall_hold_%0d: got %b want 001", i, {AWREADY, WREADY, BVALID});
      end
    end
    BREADY = 1;
    tick();
    n_cmp++;
    if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
      n_bad++; $display("FAIL stall_release: got %b want 011", {BVALID, AWREADY, WREADY});
    end
    idle_inputs();
    run_write(32'h24, 32'h5A5A5A5A, 4'hF, 0, 0, 0, 0, gv, as, ds, ss, bs, vc, lat, pok, to);
    n_cmp++;
    if (to || !gv || as !== 32'h24 || ds !== 32'h5A5A5A5A || bs !== 2'b00 || !pok) begin
      n_bad++; $display("FAIL stall_next_write: got v=%0d a=%h d=%h b=%b want 1 24 5a5a5a5a 00", gv, as, ds, bs);
    end
  endtask

  task automatic test_read_during_write;
    AWADDR = 32'h40; WDATA = 32'h0BADF00D; WSTRB = 4'h1;
    AWVALID = 1; WVALID = 1; write_ready = 0;
    tick();
    AWVALID = 0; WVALID = 0;
    tick();
    n_cmp++;
    if (write_valid !== 1'b1 || ARREADY !== 1'b1) begin
      n_bad++; $display("FAIL rd_setup: got wv=%b arready=%b want 1 1", write_valid, ARREADY);
    end
    ARADDR = 32'h0; ARVALID = 1; RREADY = 0;
    tick();
    ARVALID = 0;
    n_cmp++;
    if ({RVALID, ARREADY} !== 2'b10 || RDATA !== 32'h0 || RRESP !== 2'b10 || write_valid !== 1'b1) begin
      n_bad++; $display("FAIL rd_response: got rv/ar=%b rdata=%h rresp=%b wv=%b want 10 0 10 1",
                        {RVALID, ARREADY}, RDATA, RRESP, write_valid);
    end
    RREADY = 1; write_ready = 1; BREADY = 1;
    tick();
    n_cmp++;
    if ({RVALID, ARREADY, write_valid, BVALID, BRESP} !== 6'b010100) begin
      n_bad++; $display("FAIL rd_concurrent: got %b want 010100", {RVALID, ARREADY, write_valid, BVALID, BRESP});
    end
    RREADY = 0; write_ready = 0;
    tick();
    BREADY = 0;
    n_cmp++;
    if (BVALID !== 1'b0 || error_count !== 16'(model_err)) begin
      n_bad++; $display("FAIL rd_no_error: got bv=%b err=%0d want 0 %0d", BVALID, error_count, model_err);
    end
  endtask

  task automatic test_random;
    bit gv, pok, to, inwin; logic [31:0] a, d, as, ds; logic [3:0] s, ss; logic [1:0] bs; int vc, lat;
    logic [31:0] edges [4];
    edges[0] = 32'h0; edges[1] = 32'hFFF; edges[2] = 32'h1000; edges[3] = 32'hFFFFFFFC;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 'hFFF);
        1: a = 32'h1000 + $urandom_range(0, 'hFFFF);
        2: a = edges[$urandom_range(0, 3)];
        default: a = $urandom;
      endcase
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      inwin = model_in_window(a);
      run_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), gv, as, ds, ss, bs, vc, lat, pok, to);
      if (!inwin && model_err < 65535) model_err++;
      n_cmp++;
      if (to || gv !== inwin || bs !== (inwin ? 2'b00 : 2'b10) || lat !== 1 || !pok) begin
        n_bad++; $display("FAIL rand_%0d_resp: addr=%h got to=%0d v=%0d b=%b lat=%0d proto=%0d want v=%0d",
                          t, a, to, gv, bs, lat, pok, inwin);
      end
      if (inwin) begin
        n_cmp++;
        if (as !== a || ds !== d || ss !== s) begin
          n_bad++; $display("FAIL rand_%0d_payload: got a=%h d=%h s=%h want a=%h d=%h s=%h", t, as, ds, ss, a, d, s);
        end
      end
      n_cmp++;
      if (error_count !== 16'(model_err)) begin
        n_bad++; $display("FAIL rand_%0d_errcnt: got %0d want %0d", t, error_count, model_err);
      end
    end
  endtask

  task automatic test_async_reset;
    bit stray;
    AWADDR = 32'h80; WDATA = 32'h12345678; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1; write_ready = 0;
    tick();
    AWVALID = 0; WVALID = 0;
    tick();
    n_cmp++;
    if (write_valid !== 1'b1) begin
      n_bad++; $display("FAIL areset_setup: got wv=%b want 1", write_valid);
    end
    #3 rst = 1;
    #1;
    model_err = 0;
    n_cmp++;
    if ({write_valid, BVALID, AWREADY, WREADY, ARREADY} !== 5'b0 || error_count !== 16'd0) begin
      n_bad++; $display("FAIL areset_immediate: got %b err=%0d want 00000 0",
                        {write_valid, BVALID, AWREADY, WREADY, ARREADY}, error_count);
    end
    write_ready = 1; BREADY = 1;
    @(negedge clk); @(negedge clk);
    rst = 0;
    tick();
    n_cmp++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      n_bad++; $display("FAIL areset_release: got %b want 111", {AWREADY, WREADY, ARREADY});
    end
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      if (BVALID || write_valid) stray = 1;
      tick();
    end
    n_cmp++;
    if (stray !== 1'b0) begin
      n_bad++; $display("FAIL areset_no_stale_b: got stray=%0d want 0", stray);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_same_edge();
    test_w_leads();
    test_window();
    test_bready_stall();
    test_read_during_write();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
